// File: rtl/fetch_stage.sv
// IF stage: PC register, branch predecode, optional 2-bit BHT, IF/ID register.
// Define FETCH_BHT_EN for dynamic prediction; otherwise static not-taken.
module fetch_stage #(
    parameter int          BHT_ENTRIES = 64,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        bp_update,
    input  logic [31:0] bp_pc,
    input  logic        bp_taken,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_IF,
    output logic [31:0] pc_IF,
    output logic [31:0] pcnext_IF,
    output logic        prediction_IF
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcnext;
        logic        pred;
    } if_id_t;

    logic [31:0] r_pc;
    if_id_t      r_ifid;

    logic [31:0] w_bimm;
    logic [31:0] w_target;
    logic [31:0] w_seq;
    logic [31:0] w_pc_next;
    logic        w_pred;

    assign w_bimm   = {{19{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                       imem_rdata[30:25], imem_rdata[11:8], 1'b0};
    assign w_target = r_pc + w_bimm;
    assign w_seq    = r_pc + 32'd4;

`ifdef FETCH_BHT_EN
    localparam int IDXW = $clog2(BHT_ENTRIES);

    logic [1:0]      r_bht [BHT_ENTRIES];
    logic [IDXW-1:0] w_rd_idx;
    logic [IDXW-1:0] w_wr_idx;
    logic            w_is_branch;
    logic            w_unused_bp;

    assign w_is_branch = (imem_rdata[6:0] == 7'b1100011);
    assign w_rd_idx    = r_pc[IDXW+1:2];
    assign w_wr_idx    = bp_pc[IDXW+1:2];
    assign w_pred      = w_is_branch & r_bht[w_rd_idx][1];
    assign w_unused_bp = ^{bp_pc[31:IDXW+2], bp_pc[1:0]};

    // Lookup reads the pre-edge counter, so same-cycle training is seen next cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (bp_update) begin
            if (bp_taken) begin
                if (r_bht[w_wr_idx] != 2'b11) begin
                    r_bht[w_wr_idx] <= r_bht[w_wr_idx] + 2'd1;
                end
            end else begin
                if (r_bht[w_wr_idx] != 2'b00) begin
                    r_bht[w_wr_idx] <= r_bht[w_wr_idx] - 2'd1;
                end
            end
        end
    end
`else
    logic w_unused_bp;

    assign w_pred      = 1'b0;
    assign w_unused_bp = ^{bp_update, bp_taken, bp_pc};
`endif

    always_comb begin
        w_pc_next = w_seq;
        if (redirect_valid) begin
            w_pc_next = redirect_pc;
        end else if (stall) begin
            w_pc_next = r_pc;
        end else if (w_pred) begin
            w_pc_next = w_target;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ifid <= '{instr: NOP, pc: '0, pcnext: '0, pred: 1'b0};
        end else if (flush) begin
            r_ifid.instr <= NOP;
            r_ifid.pred  <= 1'b0;
        end else if (!stall) begin
            r_ifid <= '{instr: imem_rdata, pc: r_pc, pcnext: w_seq, pred: w_pred};
        end
    end

    assign imem_addr     = r_pc;
    assign instr_IF      = r_ifid.instr;
    assign pc_IF         = r_ifid.pc;
    assign pcnext_IF     = r_ifid.pcnext;
    assign prediction_IF = r_ifid.pred;
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios, then random traffic
// against an abstract model of PC selection, IF/ID and the counter table.
module tb_fetch_stage;
    localparam int          N   = 64;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_BHT_EN
    localparam bit BHT_ON = 1'b1;
`else
    localparam bit BHT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        bp_update = 1'b0;
    logic [31:0] bp_pc = '0;
    logic        bp_taken = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr_IF;
    logic [31:0] pc_IF;
    logic [31:0] pcnext_IF;
    logic        prediction_IF;

    logic [31:0] mem [256];
    assign imem_rdata = mem[imem_addr[9:2]];

    fetch_stage #(.BHT_ENTRIES(N), .RESET_PC(32'h0)) dut (
        .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .bp_update(bp_update), .bp_pc(bp_pc), .bp_taken(bp_taken),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr_IF(instr_IF), .pc_IF(pc_IF), .pcnext_IF(pcnext_IF),
        .prediction_IF(prediction_IF)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcn;
        logic        pred;
    } exp_t;

    exp_t q[$];
    int errors = 0;
    int checks = 0;

    logic [31:0] m_pc, m_instr, m_pcif, m_pcn;
    logic        m_pred;
    int          bht [N];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are presented after every clock edge and reset assertion
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge rstn);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("imem_addr", imem_addr, e.addr);
                chk("instr_IF", instr_IF, e.instr);
                chk("pc_IF", pc_IF, e.pc);
                chk("pcnext_IF", pcnext_IF, e.pcn);
                chk("prediction_IF", {31'b0, prediction_IF}, {31'b0, e.pred});
            end
        end
    end

    function automatic void m_reset();
        m_pc = 32'h0;
        m_instr = NOP;
        m_pcif = 32'h0;
        m_pcn = 32'h0;
        m_pred = 1'b0;
        for (int i = 0; i < N; i++) bht[i] = 1;
    endfunction

    function automatic void push_exp();
        q.push_back('{addr: m_pc, instr: m_instr, pc: m_pcif, pcn: m_pcn, pred: m_pred});
    endfunction

    function automatic void m_step(bit st, bit fl, bit rv, logic [31:0] rpc,
                                   bit bu, logic [31:0] bpc, bit bt);
        logic [31:0] w;
        logic [12:0] b;
        logic [31:0] tgt;
        bit          taken;
        int          ri, wi;
        w = mem[m_pc[9:2]];
        b = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        tgt = m_pc + 32'($signed(b));
        ri = int'((m_pc >> 2) % N);
        taken = BHT_ON && (w[6:0] == 7'h63) && (bht[ri] >= 2);
        if (fl) begin
            m_instr = NOP;
            m_pred = 1'b0;
        end else if (!st) begin
            m_instr = w;
            m_pcif = m_pc;
            m_pcn = m_pc + 32'd4;
            m_pred = taken;
        end
        if (rv) m_pc = rpc;
        else if (st) m_pc = m_pc;
        else if (taken) m_pc = tgt;
        else m_pc = m_pc + 32'd4;
        if (bu) begin
            wi = int'((bpc >> 2) % N);
            if (bt) bht[wi] = (bht[wi] == 3) ? 3 : bht[wi] + 1;
            else bht[wi] = (bht[wi] == 0) ? 0 : bht[wi] - 1;
        end
    endfunction

    task automatic cyc(bit rl, bit st, bit fl, bit rv, logic [31:0] rpc,
                       bit bu, logic [31:0] bpc, bit bt);
        stall = st;
        flush = fl;
        redirect_valid = rv;
        redirect_pc = rpc;
        bp_update = bu;
        bp_pc = bpc;
        bp_taken = bt;
        if (rl) begin
            m_reset();
            if (rstn) push_exp();
            push_exp();
            rstn = 1'b0;
        end else begin
            rstn = 1'b1;
            m_step(st, fl, rv, rpc, bu, bpc, bt);
            push_exp();
        end
        @(posedge clk);
        #2;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic redir(logic [31:0] a);
        cyc(0, 0, 0, 1, a, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] w;
        int r;
        for (int i = 0; i < 256; i++) mem[i] = NOP;
        mem[8] = 32'h0000_0863;
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        run(12);
        cyc(0, 0, 0, 0, 0, 1, 32'h20, 1);
        cyc(0, 0, 0, 0, 0, 1, 32'h20, 1);
        redir(32'h20);
        run(3);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 1, 32'h20, 1);
        cyc(0, 0, 0, 0, 0, 1, 32'h20, 0);
        redir(32'h20);
        run(3);
        redir(32'h40);
        run(1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 1, 32'h100, 0, 0, 0);
        run(2);
        cyc(0, 0, 1, 1, 32'h200, 0, 0, 0);
        run(2);
        redir(32'hFFFF_FFF8);
        run(3);
        redir(32'h80);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        run(4);

        for (int i = 0; i < 256; i++) begin
            w = $urandom();
            r = $urandom_range(0, 9);
            if (r < 4) w[6:0] = 7'h63;
            else if (r < 6) w = NOP;
            else if (w[6:0] == 7'h63) w[0] = 1'b0;
            mem[i] = w;
        end
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & 32'h3FC);
            cyc($urandom_range(0, 199) == 0,
                $urandom_range(0, 99) < 15,
                $urandom_range(0, 99) < 10,
                $urandom_range(0, 99) < 10,
                rpc,
                $urandom_range(0, 99) < 40,
                $urandom() & 32'h3FC,
                $urandom_range(0, 99) < 70);
        end
        @(posedge clk);
        #3;
        chk("scoreboard_drain", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
